cntclk_bank: RTL and testbench
==============================

Name: cntclk_bank

Overview:
Multi-channel compare-counter clock generator and the parametrised successor of the single-channel divider. Each channel has a down-counter that counts from a programmable reload value to 0. Each channel drives a zero flag and a divided clock output. Channels add per-channel enable, auto-reload or one-shot mode, and a channel-addressed load port plus a read-back port, which replace the old bidirectional value bus. The block sits between the register interface and the peripheral timing logic that consume divided clocks and tick pulses.

Parameters:
WIDTH, 16, counter and reload width in bits.
CHANNELS, 4, number of independent channels (1..16; need not be a power of 2).
CHW, $clog2(CHANNELS) min 1, width of channel-select fields (derived, do not override).

Ports:
i_clk  input  1  counter clock, all state updates on rising edge.
inner_rst_n  input  1  reset inner_rst_n, asynchronous, active-low.
i_en  input  CHANNELS  per-channel count enable; bit k gates channel k.
i_load  input  1  load strobe, sampled on rising edge.
i_load_ch  input  CHW  channel addressed by i_load.
i_load_value  input  WIDTH  reload value written on load.
i_load_oneshot  input  1  mode written on load: 0 = auto-reload, 1 = one-shot.
i_rd_ch  input  CHW  channel selected for read-back.
o_rd_value  output  WIDTH  current count of channel i_rd_ch (combinational mux).
o_zero  output  CHANNELS  bit k high while channel k count == 0 (combinational).
o_done  output  CHANNELS  bit k high when one-shot channel k has expired.
o_clk  output  CHANNELS  divided clock of each channel, registered.

Behaviour:
- Reset (inner_rst_n low, async): every count = {WIDTH{1'b1}}, reload = {WIDTH{1'b1}}, mode = auto, o_clk = 0, o_done = 0. This gives o_zero = 0 and o_rd_value = all ones. State holds while reset is low. Release is synchronous to the next i_clk edge by design.
- Per-channel priority at each edge: load > zero-event > decrement > hold.
- Load (i_load=1, i_load_ch=k < CHANNELS): reload_k <= i_load_value, mode_k <= i_load_oneshot, count_k <= i_load_value, o_clk[k] <= 0, o_done[k] <= 0.
  - Takes effect regardless of i_en[k].
  - i_load_ch >= CHANNELS: ignored, no state change.
- Decrement: i_en[k]=1, no load, count_k != 0: count_k <= count_k - 1.
- Zero event: i_en[k]=1, no load, count_k == 0, o_done[k]=0:
  - Auto mode: count_k <= reload_k, o_clk[k] toggles.
  - One-shot mode: count_k stays 0, o_clk[k] toggles once, o_done[k] <= 1.
- One-shot expired (o_done[k]=1): count, o_clk and o_done hold until the next load to channel k or reset. o_zero[k] stays high.
- i_en[k]=0: count_k, o_clk[k] and o_done[k] hold. o_zero[k] still reflects count_k == 0.
- Timing for auto mode with reload R and continuous enable:
  - o_zero[k] is high for 1 cycle in every R+1 cycles.
  - o_clk[k] half-period = R+1 cycles, full period = 2(R+1).
  - R = 0: o_zero[k] constantly high and o_clk[k] toggles every cycle (divide by 2).
- Latency:
  - A load on edge n gives count = value after edge n.
  - The first zero event falls at edge n+value+1 (enable continuous).
- No wrap below zero. The counter never decrements from 0.
- Channels are fully independent. A load to channel j never disturbs channel k != j.
- o_rd_value: combinational mux of count[i_rd_ch]. Returns 0 when i_rd_ch >= CHANNELS.

Decomposition:
- Package cntclk_pkg:
  - Mode enum (CNT_MODE_AUTO = 1'b0, CNT_MODE_ONESHOT = 1'b1).
  - Function default_reload(width) returning all ones.
  - CHW derivation helper.
- Sub-module cntclk_chan: one channel (count, reload, mode, o_clk, o_done, zero compare), with a scalar load strobe, value and mode.
- cntclk_bank: decodes i_load_ch into per-channel strobes, instantiates CHANNELS cntclk_chan via generate, and muxes read-back.

Test Plan:
- Reset then release with i_en=all 1, no load, WIDTH=16 -> every o_clk=0, o_rd_value=16'hFFFF. First o_zero after 65535 decrements, then o_clk[k] rises.
- Load ch1 value 3 auto, i_en[1]=1 -> o_zero[1] pulses every 4 cycles, o_clk[1] period 8 cycles, ch0/2/3 counts unaffected.
- Load ch2 value 0 auto -> o_zero[2] constantly 1, o_clk[2] toggles every cycle. Then load ch2 value 2 -> o_clk[2] cleared to 0, half-period 3.
- Load ch0 value 2 one-shot -> o_rd_value(ch0) 2,1,0. On the next edge o_clk[0]=1 and o_done[0]=1, then everything holds for 20 cycles. A reload clears o_done[0] and o_clk[0].
- Drop i_en[3] at count 5 for 10 cycles -> count stays 5, o_clk[3] stable. Load ch3 on the same edge its count is 0 -> load wins, o_clk[3]=0, no toggle.
- CHANNELS=3: load with i_load_ch=3 -> no channel changes, o_rd_value with i_rd_ch=3 is 0. Assert inner_rst_n low mid-count with no clock edge -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/cntclk_pkg.sv
// Shared types and helpers for the compare-counter clock bank.
package cntclk_pkg;

    // Per-channel counting mode captured on load.
    typedef enum logic {
        CNT_MODE_AUTO    = 1'b0,
        CNT_MODE_ONESHOT = 1'b1
    } cnt_mode_e;

    // All-ones value of the given width, used as the reset count and reload.
    function automatic logic [63:0] default_reload(input int width);
        return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    endfunction

    // Width of a channel-select field; never narrower than one bit.
    function automatic int chw_of(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/cntclk_chan.sv
// One compare-counter channel: down-counter with reload, mode, zero flag,
// divided clock and one-shot done flag.
module cntclk_chan
    import cntclk_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             inner_rst_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_load_oneshot,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero,
    output logic             o_done,
    output logic             o_clk
);

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(default_reload(WIDTH));

    logic [WIDTH-1:0] reload;
    cnt_mode_e        mode;

    // Zero flag follows the live count, even while the channel is disabled.
    assign o_zero = (o_count == '0);

    // Channel state: load beats a zero event, which beats a plain decrement.
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the async reset sits in the sensitivity list.
    always_ff @(posedge i_clk or negedge inner_rst_n) begin
        if (!inner_rst_n) begin
            o_count <= RST_VAL;
            reload  <= RST_VAL;
            mode    <= CNT_MODE_AUTO;
            o_clk   <= 1'b0;
            o_done  <= 1'b0;
        end else if (i_load) begin
            o_count <= i_load_value;
            reload  <= i_load_value;
            mode    <= cnt_mode_e'(i_load_oneshot);
            o_clk   <= 1'b0;
            o_done  <= 1'b0;
        end else if (i_en && !o_done) begin
            if (o_zero) begin
                o_clk <= ~o_clk;
                if (mode == CNT_MODE_ONESHOT) begin
                    o_done <= 1'b1;
                end else begin
                    o_count <= reload;
                end
            end else begin
                o_count <= o_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cntclk_bank.sv
// Bank of independent compare-counter channels with a channel-addressed load
// port and a combinational read-back mux.
module cntclk_bank
    import cntclk_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int CHW      = chw_of(CHANNELS)
) (
    input  logic                i_clk,
    input  logic                inner_rst_n,
    input  logic [CHANNELS-1:0] i_en,
    input  logic                i_load,
    input  logic [CHW-1:0]      i_load_ch,
    input  logic [WIDTH-1:0]    i_load_value,
    input  logic                i_load_oneshot,
    input  logic [CHW-1:0]      i_rd_ch,
    output logic [WIDTH-1:0]    o_rd_value,
    output logic [CHANNELS-1:0] o_zero,
    output logic [CHANNELS-1:0] o_done,
    output logic [CHANNELS-1:0] o_clk
);

    logic [WIDTH-1:0] count [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        // Out-of-range channel numbers match no strobe, so they change nothing.
        logic load_k;
        assign load_k = i_load && (i_load_ch == CHW'(k));

        cntclk_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .i_clk          (i_clk),
            .inner_rst_n    (inner_rst_n),
            .i_en           (i_en[k]),
            .i_load         (load_k),
            .i_load_value   (i_load_value),
            .i_load_oneshot (i_load_oneshot),
            .o_count        (count[k]),
            .o_zero         (o_zero[k]),
            .o_done         (o_done[k]),
            .o_clk          (o_clk[k])
        );
    end

    // Read-back mux; an unpopulated channel number reads as zero.
    // NOTE: the default assignment ahead of the loop keeps this purely
    // combinational for every select value.
    always_comb begin
        o_rd_value = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (i_rd_ch == CHW'(k)) begin
                o_rd_value = count[k];
            end
        end
    end

endmodule

// File: tb/tb_cntclk_bank.sv
// Self-checking bench for cntclk_bank (WIDTH=16, CHANNELS=3) against a
// rule-level reference model of each channel.
module tb_cntclk_bank;

    localparam int W  = 16;
    localparam int NC = 3;

    logic          i_clk = 1'b0;
    logic          inner_rst_n;
    logic [NC-1:0] i_en;
    logic          i_load;
    logic [1:0]    i_load_ch;
    logic [W-1:0]  i_load_value;
    logic          i_load_oneshot;
    logic [1:0]    i_rd_ch;
    logic [W-1:0]  o_rd_value;
    logic [NC-1:0] o_zero;
    logic [NC-1:0] o_done;
    logic [NC-1:0] o_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state per channel.
    logic [W-1:0] m_cnt [NC];
    logic [W-1:0] m_rel [NC];
    logic         m_os  [NC];
    logic         m_clk [NC];
    logic         m_done[NC];

    cntclk_bank #(
        .WIDTH    (W),
        .CHANNELS (NC)
    ) dut (
        .i_clk          (i_clk),
        .inner_rst_n    (inner_rst_n),
        .i_en           (i_en),
        .i_load         (i_load),
        .i_load_ch      (i_load_ch),
        .i_load_value   (i_load_value),
        .i_load_oneshot (i_load_oneshot),
        .i_rd_ch        (i_rd_ch),
        .o_rd_value     (o_rd_value),
        .o_zero         (o_zero),
        .o_done         (o_done),
        .o_clk          (o_clk)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_cnt[k]  = 16'hFFFF;
            m_rel[k]  = 16'hFFFF;
            m_os[k]   = 1'b0;
            m_clk[k]  = 1'b0;
            m_done[k] = 1'b0;
        end
    endtask

    // One clock edge of the behavioural rules, using the inputs now applied.
    task automatic model_step();
        for (int k = 0; k < NC; k++) begin
            if (i_load && int'(i_load_ch) == k) begin
                m_rel[k]  = i_load_value;
                m_os[k]   = i_load_oneshot;
                m_cnt[k]  = i_load_value;
                m_clk[k]  = 1'b0;
                m_done[k] = 1'b0;
            end else if (i_en[k] && !m_done[k]) begin
                if (m_cnt[k] == 0) begin
                    m_clk[k] = ~m_clk[k];
                    if (m_os[k]) m_done[k] = 1'b1;
                    else         m_cnt[k]  = m_rel[k];
                end else begin
                    m_cnt[k] = m_cnt[k] - 16'd1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [1:0]   rc;
        logic [W-1:0] exp_rd;
        rc = 2'($urandom_range(0, 3));
        i_rd_ch = rc;
        #1;
        for (int k = 0; k < NC; k++) begin
            check($sformatf("zero[%0d]", k), 32'(o_zero[k]), 32'(m_cnt[k] == 0));
            check($sformatf("done[%0d]", k), 32'(o_done[k]), 32'(m_done[k]));
            check($sformatf("clk[%0d]", k),  32'(o_clk[k]),  32'(m_clk[k]));
        end
        exp_rd = (int'(rc) < NC) ? m_cnt[rc] : '0;
        check($sformatf("rd_value[%0d]", rc), 32'(o_rd_value), 32'(exp_rd));
    endtask

    task automatic cycle();
        @(posedge i_clk);
        if (inner_rst_n) model_step();
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load(input int ch, input logic [W-1:0] val, input logic os);
        i_load         = 1'b1;
        i_load_ch      = 2'(ch);
        i_load_value   = val;
        i_load_oneshot = os;
        cycle();
        i_load = 1'b0;
    endtask

    // Bounded wait until the modelled count of a channel reaches a target.
    task automatic wait_count(input int ch, input logic [W-1:0] target, input int budget);
        for (int i = 0; i < budget && m_cnt[ch] != target; i++) cycle();
        check($sformatf("wait_cnt[%0d]", ch), 32'(m_cnt[ch]), 32'(target));
    endtask

    initial begin
        inner_rst_n    = 1'b0;
        i_en           = '0;
        i_load         = 1'b0;
        i_load_ch      = '0;
        i_load_value   = '0;
        i_load_oneshot = 1'b0;
        i_rd_ch        = '0;
        model_reset();

        // Reset values, then free-run from all-ones through the first zero event.
        @(negedge i_clk);
        compare_all();
        run(2);
        i_en        = '1;
        inner_rst_n = 1'b1;
        run(65540);

        // Auto reload 3 on channel 1: zero every 4 cycles, clock period 8.
        load(1, 16'd3, 1'b0);
        run(20);

        // Reload 0 divides by two; reloading clears the clock.
        load(2, 16'd0, 1'b0);
        run(10);
        load(2, 16'd2, 1'b0);
        run(12);

        // One-shot from 2: expires, holds, then a reload clears it.
        load(0, 16'd2, 1'b1);
        run(25);
        load(0, 16'd5, 1'b0);
        run(8);

        // Enable gating at count 5, then a load on the zero cycle wins.
        load(2, 16'd8, 1'b0);
        wait_count(2, 16'd5, 20);
        i_en[2] = 1'b0;
        run(10);
        i_en[2] = 1'b1;
        wait_count(2, 16'd0, 20);
        load(2, 16'd4, 1'b0);
        run(6);

        // Unpopulated channel number: load ignored, read-back zero.
        load(3, 16'h1234, 1'b1);
        run(4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            i_en = NC'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                i_load         = 1'b1;
                i_load_ch      = 2'($urandom_range(0, 3));
                i_load_value   = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
                i_load_oneshot = 1'($urandom);
            end else begin
                i_load = 1'b0;
            end
            cycle();
        end
        i_load = 1'b0;
        i_en   = '1;

        // Asynchronous reset mid-count, away from any edge.
        load(0, 16'd9, 1'b0);
        load(1, 16'd1, 1'b1);
        run(5);
        #2;
        inner_rst_n = 1'b0;
        model_reset();
        compare_all();
        run(3);
        inner_rst_n = 1'b1;
        run(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
